// File: rtl/mc_ctrl_if.sv
// Control bus between the multicycle MIPS controller and its datapath.
//   Datapath -> controller : op (IR[31:26]), zero (ALU zero flag), mem_rdy
//   Controller -> datapath : memory request/write, IR/PC/regfile enables,
//                            mux selects, ALU operation, error status
// Modports: master = controller side, slave = datapath side.
interface mc_ctrl_if;
  logic [5:0] op;
  logic       zero;
  logic       mem_rdy;
  logic       mem_req;
  logic       mem_we;
  logic       iord;
  logic       ir_we;
  logic       pc_en;
  logic       rf_we;
  logic       regdst;
  logic       memtoreg;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic [1:0] pcsrc;
  logic       err;
  logic [1:0] err_code;

  modport master (
    input  op, zero, mem_rdy,
    output mem_req, mem_we, iord, ir_we, pc_en, rf_we, regdst, memtoreg,
           alusrca, alusrcb, aluop, pcsrc, err, err_code
  );

  modport slave (
    output op, zero, mem_rdy,
    input  mem_req, mem_we, iord, ir_we, pc_en, rf_we, regdst, memtoreg,
           alusrca, alusrcb, aluop, pcsrc, err, err_code
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control FSM (lw, sw, R-type, beq, addi, j).
// Sequences PC/IR/ALUOut/register file/data memory through per-state
// enables and mux selects, watchdogs stalled memory accesses and flags
// illegal opcodes with a sticky error code (first error wins).
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset (all outputs 0 while asserted)
//   bus - mc_ctrl_if.master: op/zero/mem_rdy in, control outputs out
module mc_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255  // 1..255 stalled cycles
) (
  input logic       clk,
  input logic       rst,
  mc_ctrl_if.master bus
);
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] wait_cnt_reg, wait_cnt_next;
  logic       err_reg, err_next;
  logic [1:0] err_code_reg, err_code_next;
  logic       mem_state;
  logic       timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= FETCH;
      wait_cnt_reg <= 8'd0;
      err_reg      <= 1'b0;
      err_code_reg <= 2'b00;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      err_reg      <= err_next;
      err_code_reg <= err_code_next;
    end
  end

  // A stalled memory state gives up once the counter has already seen
  // MEM_TIMEOUT-1 idle cycles; a completing access always wins.
  always_comb begin
    mem_state = (state_reg == FETCH) || (state_reg == MEMRD) || (state_reg == MEMWR);
    timeout   = mem_state && !bus.mem_rdy && (wait_cnt_reg == WAIT_LAST);
  end

  always_comb begin
    state_next    = state_reg;
    err_next      = err_reg;
    err_code_next = err_code_reg;
    case (state_reg)
      FETCH:  if (bus.mem_rdy) state_next = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXEC;
          OP_BEQ:       state_next = BRANCH;
          OP_ADDI:      state_next = ADDIEX;
          OP_J:         state_next = JUMP;
          default: begin
            state_next = FETCH;
            if (!err_reg) begin
              err_next      = 1'b1;
              err_code_next = 2'b01;
            end
          end
        endcase
      end
      MEMADR: begin
        if (bus.op == OP_LW)      state_next = MEMRD;
        else if (bus.op == OP_SW) state_next = MEMWR;
        else                      state_next = FETCH;
      end
      MEMRD:  if (bus.mem_rdy) state_next = MEMWB;
      MEMWB:  state_next = FETCH;
      MEMWR:  if (bus.mem_rdy) state_next = FETCH;
      EXEC:   state_next = ALUWB;
      ALUWB:  state_next = FETCH;
      BRANCH: state_next = FETCH;
      ADDIEX: state_next = ADDIWB;
      ADDIWB: state_next = FETCH;
      JUMP:   state_next = FETCH;
      default: state_next = FETCH;
    endcase
    if (timeout) begin
      state_next = FETCH;
      if (!err_reg) begin
        err_next      = 1'b1;
        err_code_next = 2'b10;
      end
    end
    // Counter only survives a stalled cycle that stays in the same state;
    // every state change (including timeout re-entry of FETCH) clears it.
    wait_cnt_next = (mem_state && !bus.mem_rdy && !timeout) ? wait_cnt_reg + 8'd1 : 8'd0;
  end

  // Moore decode; write enables in memory states are qualified by mem_rdy,
  // so a stalled or timed-out cycle never writes anything.
  always_comb begin
    bus.mem_req  = 1'b0;
    bus.mem_we   = 1'b0;
    bus.iord     = 1'b0;
    bus.ir_we    = 1'b0;
    bus.pc_en    = 1'b0;
    bus.rf_we    = 1'b0;
    bus.regdst   = 1'b0;
    bus.memtoreg = 1'b0;
    bus.alusrca  = 1'b0;
    bus.alusrcb  = 2'b00;
    bus.aluop    = 2'b00;
    bus.pcsrc    = 2'b00;
    if (!rst) begin
      case (state_reg)
        FETCH: begin
          bus.mem_req = 1'b1;
          bus.alusrcb = 2'b01;
          bus.ir_we   = bus.mem_rdy;
          bus.pc_en   = bus.mem_rdy;
        end
        DECODE: bus.alusrcb = 2'b11;
        MEMADR, ADDIEX: begin
          bus.alusrca = 1'b1;
          bus.alusrcb = 2'b10;
        end
        MEMRD: begin
          bus.mem_req = 1'b1;
          bus.iord    = 1'b1;
        end
        MEMWB: begin
          bus.rf_we    = 1'b1;
          bus.memtoreg = 1'b1;
        end
        MEMWR: begin
          bus.mem_req = 1'b1;
          bus.iord    = 1'b1;
          bus.mem_we  = bus.mem_rdy;
        end
        EXEC: begin
          bus.alusrca = 1'b1;
          bus.aluop   = 2'b10;
        end
        ALUWB: begin
          bus.rf_we  = 1'b1;
          bus.regdst = 1'b1;
        end
        BRANCH: begin
          bus.alusrca = 1'b1;
          bus.aluop   = 2'b01;
          bus.pcsrc   = 2'b01;
          bus.pc_en   = bus.zero;
        end
        ADDIWB: bus.rf_we = 1'b1;
        JUMP: begin
          bus.pcsrc = 2'b10;
          bus.pc_en = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.err      = err_reg;
  assign bus.err_code = err_code_reg;
endmodule

// File: tb/tb_mc_ctrl.sv
// Testbench for mc_ctrl: directed vector table, hand-written timeout/reset
// sequences, then randomized traffic against an instruction-level model.
module tb_mc_ctrl;
  localparam int TO = 4;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  // Field order: mem_req mem_we iord ir_we pc_en rf_we regdst memtoreg
  //              alusrca alusrcb aluop pcsrc
  localparam logic [14:0] V_ZERO    = 15'b0_0_0_0_0_0_0_0_0_00_00_00;
  localparam logic [14:0] V_FETCH_W = 15'b1_0_0_0_0_0_0_0_0_01_00_00;
  localparam logic [14:0] V_FETCH_R = 15'b1_0_0_1_1_0_0_0_0_01_00_00;
  localparam logic [14:0] V_DECODE  = 15'b0_0_0_0_0_0_0_0_0_11_00_00;
  localparam logic [14:0] V_MEMADR  = 15'b0_0_0_0_0_0_0_0_1_10_00_00;
  localparam logic [14:0] V_MEMRD   = 15'b1_0_1_0_0_0_0_0_0_00_00_00;
  localparam logic [14:0] V_MEMWB   = 15'b0_0_0_0_0_1_0_1_0_00_00_00;
  localparam logic [14:0] V_MEMWR_W = 15'b1_0_1_0_0_0_0_0_0_00_00_00;
  localparam logic [14:0] V_MEMWR_R = 15'b1_1_1_0_0_0_0_0_0_00_00_00;
  localparam logic [14:0] V_EXEC    = 15'b0_0_0_0_0_0_0_0_1_00_10_00;
  localparam logic [14:0] V_ALUWB   = 15'b0_0_0_0_0_1_1_0_0_00_00_00;
  localparam logic [14:0] V_BR_T    = 15'b0_0_0_0_1_0_0_0_1_00_01_01;
  localparam logic [14:0] V_BR_N    = 15'b0_0_0_0_0_0_0_0_1_00_01_01;
  localparam logic [14:0] V_ADDIWB  = 15'b0_0_0_0_0_1_0_0_0_00_00_00;
  localparam logic [14:0] V_JUMP    = 15'b0_0_0_0_1_0_0_0_0_00_00_10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mc_ctrl_if bus ();
  mc_ctrl #(.MEM_TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [5:0]  op;
    logic        rdy;
    logic        zero;
    logic [14:0] vec;
    logic [2:0]  errv;  // {err, err_code}
  } row_t;
  row_t tbl[$];

  typedef enum {S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
                S_EXEC, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP} step_e;

  function automatic logic [14:0] outs();
    return {bus.mem_req, bus.mem_we, bus.iord, bus.ir_we, bus.pc_en, bus.rf_we,
            bus.regdst, bus.memtoreg, bus.alusrca, bus.alusrcb, bus.aluop, bus.pcsrc};
  endfunction

  function automatic logic [2:0] errs();
    return {bus.err, bus.err_code};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic [5:0] o, input logic r, input logic z, input logic rs);
    @(negedge clk);
    bus.op = o; bus.mem_rdy = r; bus.zero = z; rst = rs;
    #1;
  endtask

  task automatic step_check(input string name, input logic [5:0] o, input logic r,
                            input logic z, input logic rs,
                            input logic [14:0] v, input logic [2:0] e);
    drive(o, r, z, rs);
    check({name, " outs"}, {17'd0, outs()}, {17'd0, v});
    check({name, " err"}, {29'd0, errs()}, {29'd0, e});
  endtask

  task automatic add(input logic [5:0] o, input logic r, input logic z,
                     input logic [14:0] v, input logic [2:0] e);
    row_t t;
    t.op = o; t.rdy = r; t.zero = z; t.vec = v; t.errv = e;
    tbl.push_back(t);
  endtask

  function automatic logic [14:0] exp_vec(step_e s, logic r, logic z);
    case (s)
      S_FETCH:  return r ? V_FETCH_R : V_FETCH_W;
      S_DECODE: return V_DECODE;
      S_MEMADR, S_ADDIEX: return V_MEMADR;
      S_MEMRD:  return V_MEMRD;
      S_MEMWB:  return V_MEMWB;
      S_MEMWR:  return r ? V_MEMWR_R : V_MEMWR_W;
      S_EXEC:   return V_EXEC;
      S_ALUWB:  return V_ALUWB;
      S_BRANCH: return z ? V_BR_T : V_BR_N;
      S_ADDIWB: return V_ADDIWB;
      default:  return V_JUMP;
    endcase
  endfunction

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 7))
      0: return OP_R;
      1: return OP_LW;
      2: return OP_SW;
      3: return OP_BEQ;
      4: return OP_ADDI;
      5: return OP_J;
      default: return 6'($urandom_range(0, 63));
    endcase
  endfunction

  initial begin
    step_e      cur;
    step_e      plan[$];
    int         cnt;
    logic [2:0] m_err;
    logic [5:0] cur_op;
    logic       r, z;

    rst = 1'b1; bus.op = 6'd0; bus.mem_rdy = 1'b0; bus.zero = 1'b0;

    // lw, zero wait: 5 cycles
    add(OP_LW, 1, 0, V_FETCH_R, 3'b000); add(OP_LW, 1, 0, V_DECODE, 3'b000);
    add(OP_LW, 1, 0, V_MEMADR, 3'b000);  add(OP_LW, 1, 0, V_MEMRD, 3'b000);
    add(OP_LW, 1, 0, V_MEMWB, 3'b000);
    // sw with three stalled cycles in MEMWR: 7 cycles
    add(OP_SW, 1, 0, V_FETCH_R, 3'b000); add(OP_SW, 1, 0, V_DECODE, 3'b000);
    add(OP_SW, 1, 0, V_MEMADR, 3'b000);  add(OP_SW, 0, 0, V_MEMWR_W, 3'b000);
    add(OP_SW, 0, 0, V_MEMWR_W, 3'b000); add(OP_SW, 0, 0, V_MEMWR_W, 3'b000);
    add(OP_SW, 1, 0, V_MEMWR_R, 3'b000);
    // beq taken, then not taken
    add(OP_BEQ, 1, 1, V_FETCH_R, 3'b000); add(OP_BEQ, 1, 1, V_DECODE, 3'b000);
    add(OP_BEQ, 1, 1, V_BR_T, 3'b000);
    add(OP_BEQ, 1, 0, V_FETCH_R, 3'b000); add(OP_BEQ, 1, 0, V_DECODE, 3'b000);
    add(OP_BEQ, 1, 0, V_BR_N, 3'b000);
    // R-type, addi, j
    add(OP_R, 1, 0, V_FETCH_R, 3'b000); add(OP_R, 1, 0, V_DECODE, 3'b000);
    add(OP_R, 1, 0, V_EXEC, 3'b000);    add(OP_R, 1, 0, V_ALUWB, 3'b000);
    add(OP_ADDI, 1, 0, V_FETCH_R, 3'b000); add(OP_ADDI, 1, 0, V_DECODE, 3'b000);
    add(OP_ADDI, 1, 0, V_MEMADR, 3'b000);  add(OP_ADDI, 1, 0, V_ADDIWB, 3'b000);
    add(OP_J, 1, 0, V_FETCH_R, 3'b000); add(OP_J, 1, 0, V_DECODE, 3'b000);
    add(OP_J, 1, 0, V_JUMP, 3'b000);
    // illegal opcode, then a FETCH timeout that must not overwrite code 01
    add(OP_BAD, 1, 0, V_FETCH_R, 3'b000); add(OP_BAD, 1, 0, V_DECODE, 3'b000);
    add(OP_BAD, 0, 0, V_FETCH_W, 3'b101); add(OP_BAD, 0, 0, V_FETCH_W, 3'b101);
    add(OP_BAD, 0, 0, V_FETCH_W, 3'b101); add(OP_BAD, 0, 0, V_FETCH_W, 3'b101);
    add(OP_BAD, 0, 0, V_FETCH_W, 3'b101); add(OP_J, 1, 0, V_FETCH_R, 3'b101);
    add(OP_J, 1, 0, V_DECODE, 3'b101);    add(OP_J, 1, 0, V_JUMP, 3'b101);

    step_check("reset", OP_LW, 1, 1, 1, V_ZERO, 3'b000);
    step_check("reset2", OP_LW, 1, 1, 1, V_ZERO, 3'b000);
    for (int i = 0; i < tbl.size(); i++)
      step_check($sformatf("row%0d", i), tbl[i].op, tbl[i].rdy, tbl[i].zero, 1'b0,
                 tbl[i].vec, tbl[i].errv);

    // MEMRD timeout: four stalled cycles, then FETCH with code 10
    step_check("to_rst", OP_LW, 1, 0, 1, V_ZERO, 3'b000);
    step_check("to_fetch", OP_LW, 1, 0, 0, V_FETCH_R, 3'b000);
    step_check("to_dec", OP_LW, 1, 0, 0, V_DECODE, 3'b000);
    step_check("to_adr", OP_LW, 1, 0, 0, V_MEMADR, 3'b000);
    for (int i = 0; i < TO; i++)
      step_check($sformatf("to_wait%0d", i), OP_LW, 0, 0, 0, V_MEMRD, 3'b000);
    step_check("to_refetch", OP_LW, 0, 0, 0, V_FETCH_W, 3'b110);
    // reset mid-MEMRD: outputs and error clear immediately
    step_check("ab_fetch", OP_LW, 1, 0, 0, V_FETCH_R, 3'b110);
    step_check("ab_dec", OP_LW, 1, 0, 0, V_DECODE, 3'b110);
    step_check("ab_adr", OP_LW, 1, 0, 0, V_MEMADR, 3'b110);
    step_check("ab_memrd", OP_LW, 0, 0, 0, V_MEMRD, 3'b110);
    step_check("ab_rst", OP_LW, 1, 1, 1, V_ZERO, 3'b000);
    step_check("ab_after", OP_LW, 1, 0, 0, V_FETCH_R, 3'b000);

    // Randomized run against an instruction-level model: each opcode expands
    // into its list of steps; memory steps stall, complete or time out.
    step_check("rnd_rst", OP_R, 0, 0, 1, V_ZERO, 3'b000);
    cur = S_FETCH; cnt = 0; m_err = 3'b000; cur_op = OP_R;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        step_check("rnd_reset", cur_op, 1, 0, 1, V_ZERO, 3'b000);
        cur = S_FETCH; cnt = 0; m_err = 3'b000; plan.delete();
        continue;
      end
      if (cur == S_FETCH) cur_op = pick_op();
      r = ($urandom_range(0, 9) < 6);
      z = 1'($urandom_range(0, 1));
      step_check("rnd", cur_op, r, z, 0, exp_vec(cur, r, z), m_err);
      case (cur)
        S_FETCH, S_MEMRD, S_MEMWR: begin
          if (r) begin
            cnt = 0;
            if (cur == S_FETCH) cur = S_DECODE;
            else cur = (plan.size() != 0) ? plan.pop_front() : S_FETCH;
          end else if (cnt == TO - 1) begin
            cnt = 0;
            if (!m_err[2]) m_err = 3'b110;
            plan.delete();
            cur = S_FETCH;
          end else begin
            cnt++;
          end
        end
        S_DECODE: begin
          plan.delete();
          case (cur_op)
            OP_LW:   begin plan.push_back(S_MEMADR); plan.push_back(S_MEMRD); plan.push_back(S_MEMWB); end
            OP_SW:   begin plan.push_back(S_MEMADR); plan.push_back(S_MEMWR); end
            OP_R:    begin plan.push_back(S_EXEC); plan.push_back(S_ALUWB); end
            OP_BEQ:  plan.push_back(S_BRANCH);
            OP_ADDI: begin plan.push_back(S_ADDIEX); plan.push_back(S_ADDIWB); end
            OP_J:    plan.push_back(S_JUMP);
            default: if (!m_err[2]) m_err = 3'b101;
          endcase
          cur = (plan.size() != 0) ? plan.pop_front() : S_FETCH;
        end
        default: cur = (plan.size() != 0) ? plan.pop_front() : S_FETCH;
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multicycle MIPS control FSM that sequences the datapath's state registers (PC, IR, ALUOut, register file, data memory) through per-state write enables and mux selects. It sits beside the multicycle datapath, takes the IR opcode, the ALU zero flag and a memory-ready handshake, and issues one instruction at a time. It supports lw, sw, R-type, beq, addi and j. It also watchdogs stalled memory accesses and flags illegal opcodes.

Parameters:
MEM_TIMEOUT, 255, number of consecutive mem_rdy=0 cycles in one memory state before the access is aborted (1..255; wait counter is 8 bits)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
op  in  6  IR[31:26] opcode
zero  in  1  ALU zero flag (valid in BRANCH)
mem_rdy  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
mem_we  out  1  data memory write enable
iord  out  1  address select: 0=PC, 1=ALUOut
ir_we  out  1  IR write enable
pc_en  out  1  PC write enable (unconditional or taken branch)
rf_we  out  1  register file write enable
regdst  out  1  0=rt, 1=rd
memtoreg  out  1  0=ALUOut, 1=MDR
alusrca  out  1  0=PC, 1=regA
alusrcb  out  2  00=regB, 01=const 4, 10=signimm, 11=signimm<<2
aluop  out  2  00=add, 01=sub, 10=decode funct
pcsrc  out  2  00=ALU result, 01=ALUOut, 10=jump target
err  out  1  sticky error flag
err_code  out  2  01=illegal opcode, 10=memory timeout; first error wins

Behaviour:
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, addi=001000, j=000010; anything else is illegal.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
- Reset: state is set to FETCH asynchronously; wait counter=0; err=0; err_code=00. While rst=1, every output is 0. After release, FETCH outputs apply on the next cycle.
- Outputs are Moore, decoded from state. The only exceptions are the mem_rdy-qualified enables and pc_en in BRANCH. Outputs not listed for a state are 0.
- FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, ir_we=mem_rdy, pc_en=mem_rdy. Stay in FETCH until mem_rdy=1, then go to DECODE.
- DECODE: alusrca=0, alusrcb=11, aluop=00 (branch target into ALUOut). Next state: lw/sw→MEMADR, R→EXEC, beq→BRANCH, addi→ADDIEX, j→JUMP. Illegal opcode→FETCH, setting err (if still clear) with code 01.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Next: lw→MEMRD, sw→MEMWR.
- MEMRD: mem_req=1, iord=1. On mem_rdy go to MEMWB, else stay.
- MEMWB: rf_we=1, regdst=0, memtoreg=1. Next: FETCH.
- MEMWR: mem_req=1, iord=1, mem_we=mem_rdy. On mem_rdy go to FETCH, else stay.
- EXEC: alusrca=1, alusrcb=00, aluop=10. Next: ALUWB.
- ALUWB: rf_we=1, regdst=1, memtoreg=0. Next: FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, pc_en=zero. Next: FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Next: ADDIWB.
- ADDIWB: rf_we=1, regdst=0, memtoreg=0. Next: FETCH.
- JUMP: pcsrc=10, pc_en=1. Next: FETCH.
- Latency with zero memory wait: lw=5 cycles; sw, R-type, addi=4; beq, j=3. Each mem_rdy=0 cycle adds one cycle.
- Watchdog: the wait counter increments each cycle in FETCH, MEMRD or MEMWR with mem_rdy=0, and clears on any state change.
  - When a mem_rdy=0 cycle occurs with counter==MEM_TIMEOUT-1, the next state is FETCH, with no writes that cycle.
  - err sets with code 10 if clear.
  - A timeout in FETCH re-enters FETCH with the counter cleared.
- mem_rdy=1 on the timeout cycle wins over the timeout: the access completes normally.
- err and err_code clear only on reset. Operation continues after an error.
- op is sampled only in DECODE and MEMADR; the datapath holds IR stable.
- Reset asserted mid-instruction aborts it immediately: outputs go to 0 and no partial write occurs after assertion.

Test Plan:
- Reset then lw (op=100011) with mem_rdy=1 always → states FETCH,DECODE,MEMADR,MEMRD,MEMWB over 5 cycles; rf_we=1 and memtoreg=1 only in cycle 5; ir_we=pc_en=1 in cycle 1.
- sw with mem_rdy held 0 for 3 cycles in MEMWR → state holds MEMWR 4 cycles; mem_we=1 only in the final cycle; total 7 cycles.
- beq with zero=1 then zero=0 → pc_en=1 with pcsrc=01 in BRANCH for the first, pc_en=0 for the second; 3 cycles each.
- R-type, addi, j sequences → regdst=1 in ALUWB, regdst=0 in ADDIWB, pcsrc=10 with pc_en=1 in JUMP; cycle counts 4/4/3.
- op=111111 → DECODE goes to FETCH; err=1, err_code=01; no rf_we/mem_we/pc_en in that instruction. A following timeout keeps err_code=01.
- MEM_TIMEOUT=4 with mem_rdy=0 in MEMRD → after 4 wait cycles state=FETCH, err_code=10, rf_we never asserted. Asserting rst during MEMRD forces all outputs 0 that cycle and err clears.
